// File: rtl/piso_tx_pkg.sv
// Shared types and defaults for the PISO transmit scheduler.
// Holds the FSM state encoding and the default word/gap geometry.
package piso_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    localparam int WORD_W_DEF  = 10;
    localparam int GAP_CYC_DEF = 2;

    // Counter width for n states; never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_tx_sched_if.sv
// Requester handshake and shifter-control bundle of the PISO transmit scheduler.
// master = requester/shifter side, slave = scheduler.
interface piso_tx_sched_if #(
    parameter int WORD_W = piso_tx_pkg::WORD_W_DEF
);
    logic              enable;
    logic              req0_valid;
    logic [WORD_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [WORD_W-1:0] req1_data;
    logic              req1_ready;
    logic              shf_load_n;
    logic [WORD_W-1:0] shf_data;
    logic              grant_id;
    logic              busy;
    logic              frame_start;
    logic              frame_done;

    modport master (
        output enable, req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, shf_load_n, shf_data, grant_id,
               busy, frame_start, frame_done
    );

    modport slave (
        input  enable, req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, shf_load_n, shf_data, grant_id,
               busy, frame_start, frame_done
    );
endinterface

// File: rtl/piso_tx_sched_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the one
// not granted last. The pointer only moves when the grant is actually taken.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant_idx,
    output logic       grant_vld
);

    logic last_q;

    always_comb begin
        grant_vld = |req;
        if (&req) begin
            grant_idx = ~last_q;
        end else begin
            grant_idx = req[1];
        end
    end

    // Starting at 1 makes req0 the winner of the first contended round.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (advance && grant_vld) begin
            last_q <= grant_idx;
        end
    end

endmodule

// File: rtl/piso_tx_sched.sv
// Schedules words from two requesters onto a parallel-load shifter:
// accept -> LOAD (1 cycle) -> SHIFT (WORD_W cycles) -> GAP (GAP_CYC cycles).
module piso_tx_sched
    import piso_tx_pkg::*;
#(
    parameter int WORD_W  = WORD_W_DEF,
    parameter int GAP_CYC = GAP_CYC_DEF
) (
    input  logic           clk,
    input  logic           reset,
    piso_tx_sched_if.slave bus
);

    localparam int CNT_W = cnt_w(WORD_W);
    localparam int GAP_W = cnt_w(GAP_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              gid_q, gid_d;
    logic              load_n_q, load_n_d;
    logic              busy_q, busy_d;
    logic              start_q, start_d;
    logic              done_q, done_d;
    logic              gnt_idx, gnt_vld, accept;

    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       ({bus.req1_valid, bus.req0_valid}),
        .advance   (accept),
        .grant_idx (gnt_idx),
        .grant_vld (gnt_vld)
    );

    // Ready is combinational so a word offered in IDLE is taken that same cycle.
    assign accept         = !reset && (state_q == ST_IDLE) && bus.enable && gnt_vld;
    assign bus.req0_ready = accept && !gnt_idx;
    assign bus.req1_ready = accept && gnt_idx;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        data_d  = data_q;
        gid_d   = gid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_LOAD;
                    data_d  = gnt_idx ? bus.req1_data : bus.req0_data;
                    gid_d   = gnt_idx;
                end
            end
            ST_LOAD: begin
                state_d = ST_SHIFT;
                cnt_d   = '0;
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
                    cnt_d   = '0;
                    gap_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Outputs are decoded from the next state so they line up with state_q.
        load_n_d = (state_d != ST_LOAD);
        busy_d   = (state_d != ST_IDLE);
        start_d  = (state_d == ST_LOAD);
        done_d   = (state_d == ST_SHIFT) && (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            gap_q    <= '0;
            data_q   <= '0;
            gid_q    <= 1'b0;
            load_n_q <= 1'b1;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            data_q   <= data_d;
            gid_q    <= gid_d;
            load_n_q <= load_n_d;
            busy_q   <= busy_d;
            start_q  <= start_d;
            done_q   <= done_d;
        end
    end

    assign bus.shf_load_n  = load_n_q;
    assign bus.shf_data    = data_q;
    assign bus.grant_id    = gid_q;
    assign bus.busy        = busy_q;
    assign bus.frame_start = start_q;
    assign bus.frame_done  = done_q;

endmodule

// File: doc/piso_tx_sched.md
PISO_TX_SCHED -- requirements
Module: piso_tx_sched

Interface
REQ-001 The block SHALL take parameter WORD_W, default 10, as the serialized word width in bits.
REQ-002 The block SHALL take parameter GAP_CYC, default 2, as the number of idle cycles inserted after each frame; 0 is legal.
REQ-003 The block SHALL provide port clk, input, 1 bit: rising-edge clock.
REQ-004 The block SHALL provide port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL provide port enable, input, 1 bit: when high, new words may be accepted.
REQ-006 The block SHALL provide ports req0_valid and req1_valid, input, 1 bit each: requester offers a word.
REQ-007 The block SHALL provide ports req0_data and req1_data, input, WORD_W bits each: offered word.
REQ-008 The block SHALL provide ports req0_ready and req1_ready, output, 1 bit each: word accepted this cycle when valid and ready are both high.
REQ-009 The block SHALL provide port shf_load_n, output, 1 bit: shifter control; 0 = parallel load, 1 = shift with fill value 1.
REQ-010 The block SHALL provide port shf_data, output, WORD_W bits: parallel word presented to the shifter.
REQ-011 The block SHALL provide port grant_id, output, 1 bit: requester that owns the current frame.
REQ-012 The block SHALL provide port busy, output, 1 bit: high in LOAD, SHIFT and GAP.
REQ-013 The block SHALL provide ports frame_start and frame_done, output, 1 bit each: single-cycle pulses.

Function
REQ-014 The block SHALL use the FSM states IDLE, LOAD, SHIFT and GAP.
REQ-015 In IDLE with enable=1, the block SHALL assert ready combinationally to exactly one valid requester, the arbitration winner, and hold both readies low otherwise.
REQ-016 Arbitration SHALL be round-robin: a single valid requester wins; if both are valid, the requester not granted last wins.
REQ-017 On acceptance, the block SHALL register the winner's data into shf_data and its index into grant_id, then go to LOAD.
REQ-018 LOAD SHALL last exactly 1 cycle: shf_load_n=0, frame_start=1, then go to SHIFT.
REQ-019 SHIFT SHALL last exactly WORD_W cycles with shf_load_n=1, counted by a counter of width clog2(WORD_W).
REQ-020 The block SHALL pulse frame_done in the final SHIFT cycle (count==WORD_W-1), then go to GAP, or to IDLE when GAP_CYC=0.
REQ-021 GAP SHALL hold shf_load_n=1 for GAP_CYC cycles, then go to IDLE.
REQ-022 shf_load_n SHALL be 1 in every state except LOAD.
REQ-023 shf_data and grant_id SHALL remain stable from acceptance until the next acceptance.
REQ-024 Per-word occupancy SHALL be 1 (accept) + 1 (LOAD) + WORD_W + GAP_CYC cycles; the defaults give 14 cycles.
REQ-025 enable=0 SHALL block only new acceptances: a frame in progress completes normally.
REQ-026 ready SHALL be 0 in LOAD, SHIFT and GAP; valid may fall without penalty while ready is low.
REQ-027 A requester that holds valid while losing arbitration SHALL win the next arbitration if the other requester is still valid.

Reset
REQ-028 While reset=1, the block SHALL set state=IDLE, shf_load_n=1, shf_data=0, grant_id=0, busy=0, frame_start=0, frame_done=0, counters=0, and hold req0_ready=req1_ready=0.
REQ-029 Reset SHALL set the round-robin pointer to last-granted=1, so that req0 wins the first contended arbitration.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately with no frame_done pulse; the aborted word is not retried.
REQ-031 On the first clock edge after reset release, the block SHALL be able to accept a word.

Structure
REQ-032 Package piso_tx_pkg SHALL hold the FSM state enum and the default WORD_W and GAP_CYC constants.
REQ-033 The 2-way round-robin arbiter SHALL be a sub-module named rr_arb2, with inputs req[1:0] and advance, and output grant index/valid.
REQ-034 The pointer in rr_arb2 SHALL update only on an accepted handshake.

Verification
REQ-035 The bench SHALL cover a single word: req0_valid=1, data=10'h2A5 -> req0_ready for 1 cycle, LOAD next cycle with shf_data=10'h2A5, 10 SHIFT cycles, frame_done in cycle 12, busy low from cycle 15.
REQ-036 The bench SHALL cover contention: both valid continuously with 10'h001 and 10'h3FF -> grants alternate 0,1,0,1, with frame_start pulses every 14 cycles.
REQ-037 The bench SHALL cover the enable gate: enable=0 with req1_valid=1 -> no ready and no LOAD; raising enable -> acceptance on that cycle.
REQ-038 The bench SHALL cover reset mid-frame: reset in SHIFT cycle 5 -> all outputs at reset values, no frame_done; next word accepted on the first edge after release.
REQ-039 The bench SHALL cover GAP_CYC=0: back-to-back req0 words -> next acceptance in the cycle after frame_done; shf_load_n is low for exactly 1 cycle per word.
REQ-040 The bench SHALL cover enable falling in SHIFT: the frame completes with frame_done, then the block stays in IDLE.
